// File: rtl/spi_rx_fifo.sv
// spi_rx_fifo: oversampling SPI byte receiver feeding a show-ahead receive FIFO.
module spi_rx_fifo #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_stb,
    input  logic       spi_clk,
    input  logic       spi_dio,
    input  logic       read,
    output logic [7:0] rdata,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] stb_q, clk_q, dio_q, flush;
    logic       stb_d, clk_d, armed;
    logic [0:0] state;
    logic [2:0] bitcnt;
    logic [6:0] shreg;
    logic       push;
    logic [7:0] pdata;
    logic       stb_s, clk_s, dio_s, stb_rise, stb_fall, clk_rise;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_n;
    logic [AW:0]   cnt, cnt_n;
    logic          do_pop, do_push;
    logic [7:0]    head_n;

    always_comb begin
        stb_s    = stb_q[SYNC_STAGES-1];
        clk_s    = clk_q[SYNC_STAGES-1];
        dio_s    = dio_q[SYNC_STAGES-1];
        stb_rise = stb_s & ~stb_d;
        stb_fall = ~stb_s & stb_d;
        clk_rise = clk_s & ~clk_d;
    end

    // armed waits until the reset-loaded synchronizer values have flushed and stb is truly high
    always_ff @(posedge clk) begin
        if (!rst) begin
            stb_q     <= '1;
            clk_q     <= '1;
            dio_q     <= '1;
            stb_d     <= 1'b1;
            clk_d     <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shreg     <= 7'd0;
            push      <= 1'b0;
            pdata     <= 8'd0;
            frame_err <= 1'b0;
        end else begin
            stb_q <= {stb_q[SYNC_STAGES-2:0], spi_stb};
            clk_q <= {clk_q[SYNC_STAGES-2:0], spi_clk};
            dio_q <= {dio_q[SYNC_STAGES-2:0], spi_dio};
            stb_d <= stb_s;
            clk_d <= clk_s;
            flush <= {flush[SYNC_STAGES-2:0], 1'b1};
            armed <= armed | (flush[SYNC_STAGES-1] & stb_s);
            push  <= 1'b0;
            if (state == IDLE) begin
                bitcnt <= 3'd0;
                if (armed && stb_fall) state <= ACTIVE;
            end else if (stb_rise) begin
                state  <= IDLE;
                bitcnt <= 3'd0;
                if (bitcnt != 3'd0) frame_err <= 1'b1;
            end else if (clk_rise) begin
                bitcnt <= bitcnt + 3'd1;
                shreg  <= {dio_s, shreg[6:1]};
                if (bitcnt == 3'd7) begin
                    push  <= 1'b1;
                    pdata <= {dio_s, shreg};
                end
            end
        end
    end

    always_comb begin
        do_pop  = read && (cnt != '0);
        do_push = push && ((cnt != FULL_CNT) || do_pop);
        cnt_n   = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rptr_n  = rptr + AW'(do_pop);
        head_n  = (cnt - (AW+1)'(do_pop) == '0) ? pdata : mem[rptr_n];
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= pdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            rdata    <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            rptr  <= rptr_n;
            cnt   <= cnt_n;
            rdata <= head_n;
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);
endmodule

// File: tb/tb_spi_rx_fifo.sv
// tb_spi_rx_fifo: directed bench for spi_rx_fifo; SPI driven on clk falling edges.
module tb_spi_rx_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spi_stb = 1'b1;
    logic       spi_clk = 1'b1;
    logic       spi_dio = 1'b1;
    logic       read = 1'b0;
    logic [7:0] rdata;
    logic       empty, full, overflow, frame_err;
    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] v;

    always #5 clk = ~clk;

    spi_rx_fifo dut (
        .clk(clk), .rst(rst), .spi_stb(spi_stb), .spi_clk(spi_clk), .spi_dio(spi_dio),
        .read(read), .rdata(rdata), .empty(empty), .full(full),
        .overflow(overflow), .frame_err(frame_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, input int h);
        spi_dio = b;
        spi_clk = 1'b0;
        idle(h);
        spi_clk = 1'b1;
        idle(h);
    endtask

    task automatic spi_byte(input logic [7:0] d, input int h);
        for (int i = 0; i < 8; i++) spi_bit(d[i], h);
    endtask

    task automatic stb_low;
        spi_stb = 1'b0;
        idle(4);
    endtask

    task automatic stb_high;
        spi_stb = 1'b1;
        idle(6);
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] exp);
        check(tag, rdata, exp);
        check({tag, "_nonempty"}, empty, 8'd0);
        read = 1'b1;
        idle(1);
        read = 1'b0;
    endtask

    initial begin
        idle(3);
        check("rst_empty", empty, 8'd1);
        check("rst_full", full, 8'd0);
        check("rst_ovf", overflow, 8'd0);
        check("rst_ferr", frame_err, 8'd0);
        check("rst_rdata", rdata, 8'd0);
        rst = 1'b1;
        idle(6);

        // single byte with exact push latency
        v = 8'hA5;
        stb_low();
        for (int i = 0; i < 7; i++) spi_bit(v[i], 3);
        spi_dio = v[7];
        spi_clk = 1'b0;
        idle(3);
        spi_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("lat_before", empty, 8'd1);
        @(posedge clk);
        #1 check("lat_at", empty, 8'd0);
        idle(2);
        stb_high();
        check("a5_ferr", frame_err, 8'd0);
        pop_expect("a5", 8'hA5);
        check("a5_empty", empty, 8'd1);

        // multi-byte frame
        stb_low();
        spi_byte(8'h01, 2);
        spi_byte(8'h80, 2);
        spi_byte(8'hFF, 2);
        stb_high();
        check("multi_ferr", frame_err, 8'd0);
        pop_expect("multi0", 8'h01);
        pop_expect("multi1", 8'h80);
        pop_expect("multi2", 8'hFF);
        check("multi_empty", empty, 8'd1);

        // overflow
        stb_low();
        for (int b = 0; b < 4; b++) spi_byte(8'h10 + 8'(b), 2);
        idle(4);
        check("ovf_full", full, 8'd1);
        check("ovf_pre", overflow, 8'd0);
        spi_byte(8'h14, 2);
        idle(4);
        check("ovf_set", overflow, 8'd1);
        check("ovf_full2", full, 8'd1);
        stb_high();
        for (int b = 0; b < 4; b++) pop_expect("ovf_rd", 8'h10 + 8'(b));
        check("ovf_empty", empty, 8'd1);

        // push and pop in the same cycle while full
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(6);
        stb_low();
        for (int b = 0; b < 4; b++) spi_byte(8'h20 + 8'(b), 2);
        idle(4);
        check("sim_full_pre", full, 8'd1);
        v = 8'h24;
        for (int i = 0; i < 7; i++) spi_bit(v[i], 2);
        spi_dio = v[7];
        spi_clk = 1'b0;
        idle(2);
        spi_clk = 1'b1;
        idle(3);
        read = 1'b1;
        idle(1);
        read = 1'b0;
        check("sim_full", full, 8'd1);
        check("sim_ovf", overflow, 8'd0);
        stb_high();
        for (int b = 1; b < 5; b++) pop_expect("sim_rd", 8'h20 + 8'(b));
        check("sim_empty", empty, 8'd1);

        // truncated frame then good frame
        stb_low();
        v = 8'h1F;
        for (int i = 0; i < 5; i++) spi_bit(v[i], 2);
        stb_high();
        check("trunc_ferr", frame_err, 8'd1);
        check("trunc_empty", empty, 8'd1);
        stb_low();
        spi_byte(8'h3C, 2);
        stb_high();
        pop_expect("trunc_next", 8'h3C);

        // reset mid-frame with stb held low
        stb_low();
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 2);
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        check("mid_ferr", frame_err, 8'd0);
        check("mid_ovf", overflow, 8'd0);
        check("mid_empty", empty, 8'd1);
        check("mid_full", full, 8'd0);
        spi_byte(8'hFF, 2);
        idle(4);
        check("mid_ignored", empty, 8'd1);
        stb_high();
        stb_low();
        spi_byte(8'h5A, 2);
        stb_high();
        pop_expect("mid_5a", 8'h5A);
        check("mid_ferr2", frame_err, 8'd0);

        // loopback at the fastest transmitter timing
        stb_low();
        spi_byte(8'h00, 2);
        spi_byte(8'h7E, 2);
        spi_byte(8'hC3, 2);
        stb_high();
        pop_expect("lb0", 8'h00);
        pop_expect("lb1", 8'h7E);
        pop_expect("lb2", 8'hC3);
        check("lb_empty", empty, 8'd1);
        check("lb_ferr", frame_err, 8'd0);
        check("lb_ovf", overflow, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
